// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the SRAM controller.
// Holds the FSM state enum plus wait/base defaults.
package sram_controller_pkg;

  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam logic [31:0] ADDR_BASE_DEF   = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_controller.sv
// 32-bit load/store port onto a 16-bit async SRAM, two half-accesses.
// Ports: clk, rst (async low), wrEn/rdEn/address/writeData in, readData/ready out, sram* bus.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] sramAddr,
  output logic [15:0] sramDqOut,
  input  logic [15:0] sramDqIn,
  output logic        sramDqOe,
  output logic        sramWeN
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] read_data_q, read_data_d;

  logic        req;
  logic        last;
  logic        in_xfer;
  logic        is_high;
  logic [31:0] offset;
  logic [16:0] word;
  logic        unused_offset_bits;

  assign req     = rdEn | wrEn;
  assign last    = (cnt_q == LAST);
  assign in_xfer = (state_q == LOW) || (state_q == HIGH);
  assign is_high = (state_q == HIGH);

  // Address and data come straight from the pipeline register,
  // which the requester holds stable while ready is low.
  assign offset = address - ADDR_BASE;
  assign word   = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    read_data_d = read_data_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOW;
          wr_d    = wrEn;
          cnt_d   = '0;
        end
      end
      LOW: begin
        if (last) begin
          state_d = HIGH;
          cnt_d   = '0;
          if (!wr_q) read_data_d[15:0] = sramDqIn;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!wr_q) read_data_d[31:16] = sramDqIn;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        // A request still held here belongs to the finished access.
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      read_data_q <= read_data_d;
    end
  end

  // Bus outputs decode from the state flop so reset clears them at once.
  always_comb begin
    sramAddr  = '0;
    sramDqOut = '0;
    sramDqOe  = 1'b0;
    sramWeN   = 1'b1;
    if (in_xfer) begin
      sramAddr = {word, is_high};
      if (wr_q) begin
        sramDqOut = is_high ? writeData[31:16] : writeData[15:0];
        sramDqOe  = 1'b1;
        sramWeN   = 1'b0;
      end
    end
  end

  assign ready    = (state_q == DONE) || ((state_q == IDLE) && !req);
  assign readData = read_data_q;

endmodule
